mac_seq: RTL and testbench

MAC_SEQ -- requirements
Module: mac_seq

---
 rtl/mac_pkg.sv | 19 +
 rtl/mac_seq.sv | 146 ++++++++++++++
 tb/tb_mac_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// mac_pkg -- shared definitions for the dot-product sequencer.
//   mac_state_e    : sequencer FSM states
//   DEF_DATA_WIDTH : default operand width
//   DEF_VEC_LEN    : default operand pairs per dot product
package mac_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_ACCUM   = 3'd2,
      S_FLUSH   = 3'd3,
      S_CAPTURE = 3'd4,
      S_RESULT  = 3'd5
   } mac_state_e;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_VEC_LEN    = 8;

endpackage

// File: rtl/mac_seq.sv
// mac_seq -- sequences one dot product of VEC_LEN operand pairs through an
// external multiply-accumulate unit and presents the captured result.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   start               : begin a dot product (sampled in IDLE only)
//   ab_valid/ab_ready   : operand pair handshake, a_data/b_data carry the pair
//   mac_en/mac_clr      : accumulate enable / accumulator clear to the MAC
//   mac_a/mac_b         : registered operands to the MAC
//   mac_c               : accumulator value from the MAC
//   res_valid/res_ready : result handshake, res_data holds the dot product
//   busy                : high whenever the FSM is not IDLE
//   state_dbg           : current FSM state, for observation
//
// Handshake rule (both channels): a transfer happens on a rising edge where
// valid and ready are both high. A producer holds valid and data stable until
// that edge; ready may depend only on state, never on the matching valid.
module mac_seq
   import mac_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int VEC_LEN    = DEF_VEC_LEN
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      ab_valid,
   output logic                      ab_ready,
   input  logic [DATA_WIDTH-1:0]     a_data,
   input  logic [DATA_WIDTH-1:0]     b_data,
   output logic                      mac_en,
   output logic                      mac_clr,
   output logic [DATA_WIDTH-1:0]     mac_a,
   output logic [DATA_WIDTH-1:0]     mac_b,
   input  logic [3*DATA_WIDTH-1:0]   mac_c,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [3*DATA_WIDTH-1:0]   res_data,
   output logic                      busy,
   output mac_state_e                state_dbg
);

   localparam int CW = $clog2(VEC_LEN + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(VEC_LEN);
   localparam logic [CW-1:0] LAST_IDX = CW'(VEC_LEN - 1);

   mac_state_e                state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic                      mac_en_q, mac_en_d;
   logic                      mac_clr_q, mac_clr_d;
   logic [DATA_WIDTH-1:0]     mac_a_q, mac_a_d;
   logic [DATA_WIDTH-1:0]     mac_b_q, mac_b_d;
   logic                      res_valid_q, res_valid_d;
   logic [3*DATA_WIDTH-1:0]   res_data_q, res_data_d;
   logic                      accept;

   // Ready is a pure function of registered state, so it cannot loop back
   // through ab_valid.
   assign ab_ready = (state_q == S_ACCUM) && (cnt_q < CNT_MAX);
   assign accept   = ab_valid && ab_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mac_en_d    = 1'b0;   // enable and clear are single-cycle pulses
      mac_clr_d   = 1'b0;
      mac_a_d     = mac_a_q;
      mac_b_d     = mac_b_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_CLEAR;
               mac_clr_d = 1'b1;   // high for the whole CLEAR cycle
               cnt_d     = '0;
            end
         end
         S_CLEAR: begin
            cnt_d   = '0;
            state_d = S_ACCUM;
         end
         S_ACCUM: begin
            if (accept) begin
               mac_a_d  = a_data;
               mac_b_d  = b_data;
               mac_en_d = 1'b1;
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == LAST_IDX) begin
                  state_d = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            // The MAC absorbs the final beat on the edge leaving FLUSH.
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            res_data_d  = mac_c;
            res_valid_d = 1'b1;
            state_d     = S_RESULT;
         end
         S_RESULT: begin
            if (res_valid_q && res_ready) begin
               res_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         mac_en_q    <= 1'b0;
         mac_clr_q   <= 1'b0;
         mac_a_q     <= '0;
         mac_b_q     <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mac_en_q    <= mac_en_d;
         mac_clr_q   <= mac_clr_d;
         mac_a_q     <= mac_a_d;
         mac_b_q     <= mac_b_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
      end
   end

   assign mac_en    = mac_en_q;
   assign mac_clr   = mac_clr_q;
   assign mac_a     = mac_a_q;
   assign mac_b     = mac_b_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign busy      = (state_q != S_IDLE);
   assign state_dbg = state_q;

endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq -- directed bench for mac_seq. Two sequencers share all control
// inputs: an 8-bit one and a 2-bit one (fed the low operand bits), each paired
// with a behavioural MAC. Expected sums are hand-computed constants.
module tb_mac_seq;
   import mac_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- shared stimulus ----------------
   logic       start = 1'b0;
   logic       ab_valid = 1'b0;
   logic       res_ready = 1'b0;
   logic [7:0] a_data = '0;
   logic [7:0] b_data = '0;

   // ---------------- 8-bit instance ----------------
   logic        ab_ready, mac_en, mac_clr, res_valid, busy;
   logic [7:0]  mac_a, mac_b;
   logic [23:0] mac_c, res_data;
   mac_state_e  state_dbg;

   mac_seq #(.DATA_WIDTH(8), .VEC_LEN(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .ab_valid(ab_valid), .ab_ready(ab_ready),
      .a_data(a_data), .b_data(b_data),
      .mac_en(mac_en), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
      .mac_c(mac_c), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .busy(busy), .state_dbg(state_dbg)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       mac_c <= '0;
      else if (mac_clr) mac_c <= '0;
      else if (mac_en)  mac_c <= mac_c + ({16'd0, mac_a} * {16'd0, mac_b});
   end

   // ---------------- 2-bit instance ----------------
   logic       ab_ready2, mac_en2, mac_clr2, res_valid2, busy2;
   logic [1:0] mac_a2, mac_b2;
   logic [5:0] mac_c2, res_data2;
   mac_state_e state_dbg2;

   mac_seq #(.DATA_WIDTH(2), .VEC_LEN(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start),
      .ab_valid(ab_valid), .ab_ready(ab_ready2),
      .a_data(a_data[1:0]), .b_data(b_data[1:0]),
      .mac_en(mac_en2), .mac_clr(mac_clr2), .mac_a(mac_a2), .mac_b(mac_b2),
      .mac_c(mac_c2), .res_valid(res_valid2), .res_ready(res_ready),
      .res_data(res_data2), .busy(busy2), .state_dbg(state_dbg2)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        mac_c2 <= '0;
      else if (mac_clr2) mac_c2 <= '0;
      else if (mac_en2)  mac_c2 <= mac_c2 + ({4'd0, mac_a2} * {4'd0, mac_b2});
   end

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   // All driving and sampling happens 1 time unit after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("clear_clr", 64'(mac_clr), 64'(1));
      check_eq("clear_en", 64'(mac_en), 64'(0));
      check_eq("clear_state", 64'(state_dbg), 64'(S_CLEAR));
      check_eq("clear_ready", 64'(ab_ready), 64'(0));
      tick();
      check_eq("accum_clr", 64'(mac_clr), 64'(0));
      check_eq("accum_ready", 64'(ab_ready), 64'(1));
   endtask

   task automatic beat(input logic [7:0] a, input logic [7:0] b);
      ab_valid = 1'b1;
      a_data   = a;
      b_data   = b;
      check_eq("beat_ready", 64'(ab_ready), 64'(1));
      tick();
      ab_valid = 1'b0;
      check_eq("beat_en", 64'(mac_en), 64'(1));
      check_eq("beat_a", 64'(mac_a), 64'(a));
      check_eq("beat_b", 64'(mac_b), 64'(b));
   endtask

   task automatic bubble();
      ab_valid = 1'b0;
      tick();
      check_eq("bubble_en", 64'(mac_en), 64'(0));
      check_eq("bubble_clr", 64'(mac_clr), 64'(0));
   endtask

   // Called straight after the edge that accepted the last beat (edge 1);
   // res_valid must rise on edge 3.
   task automatic expect_result(input string tag, input logic [23:0] exp);
      check_eq({tag, "_lat1"}, 64'(res_valid), 64'(0));
      check_eq({tag, "_flush"}, 64'(state_dbg), 64'(S_FLUSH));
      check_eq({tag, "_ready0"}, 64'(ab_ready), 64'(0));
      tick();
      check_eq({tag, "_lat2"}, 64'(res_valid), 64'(0));
      check_eq({tag, "_en_off"}, 64'(mac_en), 64'(0));
      tick();
      check_eq({tag, "_lat3"}, 64'(res_valid), 64'(1));
      check_eq({tag, "_data"}, 64'(res_data), 64'(exp));
   endtask

   task automatic release_result();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check_eq("rel_valid", 64'(res_valid), 64'(0));
      check_eq("rel_busy", 64'(busy), 64'(0));
      check_eq("rel_state", 64'(state_dbg), 64'(S_IDLE));
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_state"}, 64'(state_dbg), 64'(S_IDLE));
      check_eq({tag, "_busy"}, 64'(busy), 64'(0));
      check_eq({tag, "_ready"}, 64'(ab_ready), 64'(0));
      check_eq({tag, "_en"}, 64'(mac_en), 64'(0));
      check_eq({tag, "_clr"}, 64'(mac_clr), 64'(0));
      check_eq({tag, "_a"}, 64'(mac_a), 64'(0));
      check_eq({tag, "_b"}, 64'(mac_b), 64'(0));
      check_eq({tag, "_rv"}, 64'(res_valid), 64'(0));
      check_eq({tag, "_rd"}, 64'(res_data), 64'(0));
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   int pat[7] = '{1, 0, 0, 1, 0, 1, 1};

   initial begin
      #2;
      check_all_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check_all_zero("idle");

      // 1+2+3+4 with B=1, no bubbles
      do_start();
      beat(8'd1, 8'd1); beat(8'd2, 8'd1); beat(8'd3, 8'd1); beat(8'd4, 8'd1);
      expect_result("sum10", 24'd10);
      release_result();

      // 4 * 255*255 = 260100; 2-bit instance: 4 * 3*3 = 36 (fits in 6 bits)
      do_start();
      for (int i = 0; i < 4; i++) beat(8'd255, 8'd255);
      expect_result("sum255", 24'd260100);
      check_eq("w2_valid", 64'(res_valid2), 64'(1));
      check_eq("w2_data", 64'(res_data2), 64'(36));
      release_result();

      // bubbles: valid 1,0,0,1,0,1,1 with A=2, B=3 -> 4 * 6 = 24
      do_start();
      for (int i = 0; i < 7; i++) begin
         if (pat[i] == 1) beat(8'd2, 8'd3);
         else bubble();
      end
      expect_result("sum24", 24'd24);
      release_result();

      // result held under backpressure, start ignored: 2*(1+2+3+4) = 20
      do_start();
      beat(8'd1, 8'd2); beat(8'd2, 8'd2); beat(8'd3, 8'd2); beat(8'd4, 8'd2);
      expect_result("sum20", 24'd20);
      for (int i = 0; i < 5; i++) begin
         start = (i % 2 == 0);
         tick();
         check_eq("hold_valid", 64'(res_valid), 64'(1));
         check_eq("hold_data", 64'(res_data), 64'(20));
         check_eq("hold_ready", 64'(ab_ready), 64'(0));
         check_eq("hold_state", 64'(state_dbg), 64'(S_RESULT));
      end
      start = 1'b0;
      release_result();

      // start during ACCUM has no effect: 3*(1+2+1+2) = 18
      do_start();
      beat(8'd1, 8'd3);
      start = 1'b1;
      beat(8'd2, 8'd3);
      bubble();
      check_eq("start_ign_state", 64'(state_dbg), 64'(S_ACCUM));
      start = 1'b0;
      beat(8'd1, 8'd3); beat(8'd2, 8'd3);
      expect_result("sum18", 24'd18);
      release_result();
      // second run straight after return: 4 * 25 = 100, nothing carried over
      do_start();
      for (int i = 0; i < 4; i++) beat(8'd5, 8'd5);
      expect_result("sum100", 24'd100);
      release_result();

      // asynchronous reset after 2 of 4 beats, then a fresh run = 4
      do_start();
      beat(8'd7, 8'd7); beat(8'd7, 8'd7);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check_all_zero("postrst");
      do_start();
      for (int i = 0; i < 4; i++) beat(8'd1, 8'd1);
      expect_result("sum4", 24'd4);
      release_result();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
